video_mnist_argmax: RTL

- Pixel-rate classifier back end. Sits directly downstream of the MNIST CNN core.
- Consumes the core's 70-bit per-pixel AXI4-Stream: 10 classes x 7 binary votes.
- For each class it counts the asserted votes, picks the class with the highest count, and emits the class index and its count.
- Emits a "none" class when the best count is below a runtime threshold. tuser and tlast are carried through aligned to the data.

---
 rtl/video_mnist_argmax.sv | 123 ++++++++++++
 1 files changed

// File: rtl/video_mnist_argmax.sv
// Pixel-rate argmax back end for the MNIST CNN core: per-class vote popcount,
// two-level argmax with lower-index tie-break, and a runtime "none" threshold.
module video_mnist_argmax #(
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned CLASS_NUM     = 10,
  parameter int unsigned CHANNEL_NUM   = 7,
  parameter int unsigned S_TDATA_WIDTH = CLASS_NUM * CHANNEL_NUM,
  parameter int unsigned COUNT_WIDTH   = 3,
  parameter int unsigned CLASS_WIDTH   = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [COUNT_WIDTH-1:0]   param_threshold,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [CLASS_WIDTH-1:0]   m_axi4s_tclass,
  output logic [COUNT_WIDTH-1:0]   m_axi4s_tcount,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready
);

  localparam int unsigned PAIR_NUM = (CLASS_NUM + 1) / 2;

  logic                   cke;
  logic                   valid1;
  logic                   valid2;
  logic [COUNT_WIDTH-1:0] cnt1 [CLASS_NUM];
  logic [TUSER_WIDTH-1:0] user1;
  logic                   last1;
  logic [CLASS_WIDTH-1:0] idx2 [PAIR_NUM];
  logic [COUNT_WIDTH-1:0] cnt2 [PAIR_NUM];
  logic [TUSER_WIDTH-1:0] user2;
  logic                   last2;

  logic [CLASS_WIDTH-1:0] pair_idx [PAIR_NUM];
  logic [COUNT_WIDTH-1:0] pair_cnt [PAIR_NUM];
  logic [CLASS_WIDTH-1:0] best_idx;
  logic [COUNT_WIDTH-1:0] best_cnt;
  logic [CLASS_WIDTH-1:0] res_class;

  // Whole pipeline advances together; the output slot frees when consumed or empty
  assign cke            = m_axi4s_tready | ~m_axi4s_tvalid;
  assign s_axi4s_tready = cke;

  function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [CHANNEL_NUM-1:0] v);
    logic [COUNT_WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < int'(CHANNEL_NUM); i++) begin
      s = s + COUNT_WIDTH'(v[i]);
    end
    return s;
  endfunction

  // Pairwise reduction: the odd class of a pair must be strictly greater to win
  always_comb begin
    for (int k = 0; k < int'(PAIR_NUM); k++) begin
      pair_idx[k] = CLASS_WIDTH'(2 * k);
      pair_cnt[k] = cnt1[2 * k];
      if (2 * k + 1 < int'(CLASS_NUM)) begin
        if (cnt1[2 * k + 1] > cnt1[2 * k]) begin
          pair_idx[k] = CLASS_WIDTH'(2 * k + 1);
          pair_cnt[k] = cnt1[2 * k + 1];
        end
      end
    end
  end

  // Candidates are index-ordered, so a strict compare keeps the lower index on ties
  always_comb begin
    best_idx = idx2[0];
    best_cnt = cnt2[0];
    for (int k = 1; k < int'(PAIR_NUM); k++) begin
      if (cnt2[k] > best_cnt) begin
        best_idx = idx2[k];
        best_cnt = cnt2[k];
      end
    end
    res_class = (best_cnt < param_threshold) ? CLASS_WIDTH'(CLASS_NUM) : best_idx;
  end

  // Stage 1/2 payload: qualified only by the valid flags, so no reset needed
  always_ff @(posedge aclk) begin
    if (cke) begin
      for (int c = 0; c < int'(CLASS_NUM); c++) begin
        cnt1[c] <= popcount(s_axi4s_tdata[c * CHANNEL_NUM +: CHANNEL_NUM]);
      end
      user1 <= s_axi4s_tuser;
      last1 <= s_axi4s_tlast;
      for (int k = 0; k < int'(PAIR_NUM); k++) begin
        idx2[k] <= pair_idx[k];
        cnt2[k] <= pair_cnt[k];
      end
      user2 <= user1;
      last2 <= last1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid1         <= 1'b0;
      valid2         <= 1'b0;
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tclass <= '0;
      m_axi4s_tcount <= '0;
      m_axi4s_tuser  <= '0;
      m_axi4s_tlast  <= 1'b0;
    end else if (cke) begin
      valid1         <= s_axi4s_tvalid;
      valid2         <= valid1;
      m_axi4s_tvalid <= valid2;
      m_axi4s_tclass <= res_class;
      m_axi4s_tcount <= best_cnt;
      m_axi4s_tuser  <= user2;
      m_axi4s_tlast  <= last2;
    end
  end

endmodule
